// File: rtl/wireframe_scanout.sv
// Scanout engine for the double-buffered wireframe SRAM: walks the read buffer row by
// row, checks per-row even parity, and streams pixels with coordinates over valid/ready.
module wireframe_scanout #(
  parameter int WIDTH               = 640,
  parameter int HEIGHT              = 480,
  parameter int WIREFRAME_ADDR_SIZE = 19
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           frame_ready,
  output logic                           flip,
  output logic [WIREFRAME_ADDR_SIZE-1:0] read_addr,
  input  logic                           sram_data,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic                           pix_data,
  output logic [9:0]                     pix_x,
  output logic [8:0]                     pix_y,
  output logic                           pix_sof,
  output logic                           pix_eol,
  output logic                           pix_eof,
  output logic                           parity_err,
  output logic [8:0]                     err_row,
  output logic                           busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLIP  = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [9:0] X_PAR  = 10'(WIDTH);
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);
  localparam logic [WIREFRAME_ADDR_SIZE-1:0] ADDR_ONE = WIREFRAME_ADDR_SIZE'(1);

  typedef struct packed {
    logic       data;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic [1:0]                     state;
  logic                           frame_pending;
  logic [WIREFRAME_ADDR_SIZE-1:0] addr;
  logic [9:0]                     x_cnt;
  logic [8:0]                     y_cnt;

  // Tracks the single read whose data is on sram_data this cycle.
  logic       rd_vld;
  logic       rd_par;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic       acc;

  pix_t       fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic       pop;
  logic       push;
  logic       rd_pix;
  logic [1:0] after_pop;
  logic       credit;
  logic       issue;
  logic       par_bad;
  pix_t       head;
  pix_t       entry;

  always_comb begin
    pop       = (count != 2'd0) && pix_ready;
    rd_pix    = rd_vld && !rd_par;
    push      = rd_pix;
    after_pop = count - {1'b0, pop};
    // A pixel read needs a FIFO slot when it lands next cycle, after this cycle's
    // pop and the in-flight pixel have been accounted for.
    credit    = (after_pop == 2'd0) || ((after_pop == 2'd1) && !rd_pix);
    issue     = (state == READ) && ((x_cnt == X_PAR) || credit);
    par_bad   = acc ^ sram_data;
    head      = fifo_mem[rd_ptr];
    entry.data = sram_data;
    entry.x    = rd_x;
    entry.y    = rd_y;
    entry.sof  = (rd_x == 10'd0) && (rd_y == 9'd0);
    entry.eol  = (rd_x == X_LAST);
    entry.eof  = (rd_x == X_LAST) && (rd_y == Y_LAST);
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      frame_pending <= 1'b0;
    end else if (frame_ready) begin
      frame_pending <= 1'b1;
    end else if (state == FLIP) begin
      frame_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
      addr  <= '0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (frame_pending) state <= FLIP;
        FLIP: begin
          addr  <= '0;
          x_cnt <= '0;
          y_cnt <= '0;
          state <= READ;
        end
        READ: if (issue) begin
          if (x_cnt == X_PAR) begin
            x_cnt <= '0;
            if (y_cnt == Y_LAST) begin
              state <= DRAIN;
            end else begin
              y_cnt <= y_cnt + 9'd1;
              addr  <= addr + ADDR_ONE;
            end
          end else begin
            x_cnt <= x_cnt + 10'd1;
            addr  <= addr + ADDR_ONE;
          end
        end
        DRAIN: if (!rd_vld && (count == 2'd0)) begin
          if (frame_pending) begin
            state <= FLIP;
          end else begin
            // No new frame: rescan the same buffer so the display never starves.
            addr  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      rd_vld <= 1'b0;
      rd_par <= 1'b0;
      rd_x   <= '0;
      rd_y   <= '0;
    end else begin
      rd_vld <= issue;
      rd_par <= (x_cnt == X_PAR);
      rd_x   <= x_cnt;
      rd_y   <= y_cnt;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      acc        <= 1'b0;
      parity_err <= 1'b0;
      err_row    <= '0;
    end else if (rd_vld && rd_par) begin
      parity_err <= par_bad;
      if (par_bad) err_row <= rd_y;
      acc <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (rd_pix) acc <= acc ^ sram_data;
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign flip      = (state == FLIP);
  assign busy      = (state != IDLE);
  assign read_addr = addr;
  assign pix_valid = (count != 2'd0);
  assign pix_data  = head.data;
  assign pix_x     = head.x;
  assign pix_y     = head.y;
  assign pix_sof   = head.sof;
  assign pix_eol   = head.eol;
  assign pix_eof   = head.eof;

endmodule

// File: tb/tb_wireframe_scanout.sv
// Directed bench for wireframe_scanout at WIDTH=4, HEIGHT=2 with a double-buffered SRAM model.
module tb_wireframe_scanout;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        frame_ready = 1'b0;
  logic        flip;
  logic [18:0] read_addr;
  logic        sram_data = 1'b0;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_data;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_eof;
  logic        parity_err;
  logic [8:0]  err_row;
  logic        busy;

  int total = 0;
  int bad   = 0;

  wireframe_scanout #(.WIDTH(4), .HEIGHT(2), .WIREFRAME_ADDR_SIZE(19)) dut (
    .clk(clk), .n_rst(n_rst), .frame_ready(frame_ready), .flip(flip),
    .read_addr(read_addr), .sram_data(sram_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .parity_err(parity_err), .err_row(err_row), .busy(busy)
  );

  always #5 clk = ~clk;

  // Frames: bit i is pixel (x=i%4, y=i/4); parity bit per row.
  localparam logic [7:0] FA = 8'b1110_0101;
  localparam logic [1:0] PA = 2'b10;
  localparam logic [7:0] FB = 8'b1000_0011;
  localparam logic [1:0] PB = 2'b00;  // row 1 parity corrupted

  logic [1:0][9:0] mem = '0;
  logic            rbuf = 1'b0;

  always @(posedge clk) begin
    if (flip) rbuf <= ~rbuf;
    sram_data <= (read_addr < 19'd10) ? mem[rbuf][read_addr[3:0]] : 1'b0;
  end

  typedef struct {
    logic       d;
    logic [9:0] x;
    logic [8:0] y;
    logic       sof, eol, eof;
    int         c;
  } acc_t;

  acc_t        acc_q[$];
  logic [18:0] addr_q[$];
  logic [18:0] last_addr = '1;
  int cyc = 0, flip_cnt = 0, flip_cyc = 0, fr_cyc = 0, rise_cyc = 0;
  int perr_cnt = 0, perr_first = 0, stab_bad = 0;
  logic armed = 1'b0, prev_stall = 1'b0;
  logic [22:0] prev_vec = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (n_rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (frame_ready) fr_cyc <= cyc;
      if (flip) begin
        flip_cnt  <= flip_cnt + 1;
        flip_cyc  <= cyc;
        armed     <= 1'b1;
        addr_q.delete();
        last_addr <= '1;
      end else if (busy && read_addr != last_addr) begin
        addr_q.push_back(read_addr);
        last_addr <= read_addr;
      end
      if (armed && pix_valid) begin
        rise_cyc <= cyc;
        armed    <= 1'b0;
      end
      if (parity_err) begin
        if (perr_cnt == 0) perr_first <= cyc;
        perr_cnt <= perr_cnt + 1;
      end
      if (pix_valid && pix_ready)
        acc_q.push_back('{pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, cyc});
      if (prev_stall && (!pix_valid ||
          {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof} != prev_vec))
        stab_bad <= stab_bad + 1;
      prev_stall <= pix_valid && !pix_ready;
      prev_vec   <= {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [7:0] f, input logic [1:0] p);
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) mem[~rbuf][i] = p[i / 5];
      else            mem[~rbuf][i] = f[(i / 5) * 4 + (i % 5)];
    end
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1 frame_ready = 1'b1;
    @(posedge clk); #1 frame_ready = 1'b0;
  endtask

  task automatic wait_pix(input int n);
    for (int i = 0; i < 400; i++) begin
      if (acc_q.size() >= n) break;
      tick();
    end
  endtask

  // Compare accepted pixels [base, base+8) against frame f; returns error count.
  function automatic int frame_errs(input int base, input logic [7:0] f);
    int e = 0;
    for (int k = 0; k < 8; k++) begin
      if (base + k >= acc_q.size()) begin
        e++;
      end else if (acc_q[base+k].d !== f[k] || acc_q[base+k].x !== 10'(k % 4) ||
                   acc_q[base+k].y !== 9'(k / 4) || acc_q[base+k].sof !== (k == 0) ||
                   acc_q[base+k].eol !== (k % 4 == 3) || acc_q[base+k].eof !== (k == 7)) begin
        e++;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if ({flip, pix_valid, busy, parity_err} !== 4'b0) begin bad++;
      $display("FAIL reset_ctl: got %b want 0000", {flip, pix_valid, busy, parity_err}); end
    total++; if (read_addr !== 19'd0) begin bad++;
      $display("FAIL reset_addr: got %0d want 0", read_addr); end
    total++; if ({pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, err_row} !== '0) begin bad++;
      $display("FAIL reset_pix: got %h want 0",
               {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof, err_row}); end
    n_rst = 1'b0;
    repeat (6) tick();
    total++; if (busy !== 1'b0 || flip_cnt != 0) begin bad++;
      $display("FAIL idle_after_reset: busy=%b flips=%0d want 0/0", busy, flip_cnt); end
  endtask

  task automatic test_basic_scan();
    int e;
    load_frame(FA, PA);
    pix_ready = 1'b1;
    pulse_frame();
    wait_pix(8);
    tick();
    total++; if (flip_cnt != 1) begin bad++;
      $display("FAIL basic_flips: got %0d want 1", flip_cnt); end
    total++; if (flip_cyc - fr_cyc != 2) begin bad++;
      $display("FAIL flip_latency: got %0d want 2", flip_cyc - fr_cyc); end
    total++; if (rise_cyc - fr_cyc != 5) begin bad++;
      $display("FAIL valid_latency: got %0d want 5", rise_cyc - fr_cyc); end
    e = 0;
    for (int i = 0; i < 10; i++)
      if (i >= addr_q.size() || addr_q[i] !== 19'(i)) e++;
    total++; if (e != 0) begin bad++;
      $display("FAIL addr_order: got %0d wrong want 0", e); end
    e = frame_errs(0, FA);
    total++; if (e != 0) begin bad++;
      $display("FAIL basic_pixels: got %0d wrong want 0", e); end
    total++; if (perr_cnt != 0) begin bad++;
      $display("FAIL basic_parity: got %0d errors want 0", perr_cnt); end
  endtask

  task automatic test_rescan();
    int e;
    wait_pix(16);
    e = frame_errs(8, FA);
    total++; if (e != 0) begin bad++;
      $display("FAIL rescan_pixels: got %0d wrong want 0", e); end
    total++; if (flip_cnt != 1) begin bad++;
      $display("FAIL rescan_flips: got %0d want 1", flip_cnt); end
  endtask

  task automatic test_pending_parity();
    int e;
    load_frame(FB, PB);
    wait_pix(18);
    pulse_frame();
    wait_pix(32);
    repeat (3) tick();
    total++; if (flip_cnt != 2) begin bad++;
      $display("FAIL pending_flips: got %0d want 2", flip_cnt); end
    total++; if (acc_q.size() < 24 || acc_q[23].eof !== 1'b1 || flip_cyc <= acc_q[23].c) begin
      bad++; $display("FAIL flip_after_eof: got flip at %0d want after eof", flip_cyc); end
    e = frame_errs(24, FB);
    total++; if (e != 0) begin bad++;
      $display("FAIL new_buffer_pixels: got %0d wrong want 0", e); end
    total++; if (perr_cnt != 1) begin bad++;
      $display("FAIL parity_pulses: got %0d want 1", perr_cnt); end
    total++; if (acc_q.size() < 32 || perr_first != acc_q[31].c + 1) begin bad++;
      $display("FAIL parity_timing: got %0d want eof+1", perr_first); end
    total++; if (err_row !== 9'd1) begin bad++;
      $display("FAIL err_row: got %0d want 1", err_row); end
  endtask

  task automatic test_backpressure();
    int e, n;
    logic [18:0] a4;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1 pix_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 pix_ready = 1'b0;
    repeat (4) tick();
    a4 = read_addr;
    repeat (6) tick();
    total++; if (read_addr !== a4) begin bad++;
      $display("FAIL stall_addr: got %0d want %0d", read_addr, a4); end
    total++; if (pix_valid !== 1'b1) begin bad++;
      $display("FAIL stall_valid: got %b want 1", pix_valid); end
    @(posedge clk); #1 pix_ready = 1'b1;
    repeat (30) tick();
    total++; if (stab_bad != 0) begin bad++;
      $display("FAIL stall_stable: got %0d changes want 0", stab_bad); end
    e = 0;
    n = acc_q.size();
    for (int i = 24; i < n; i++) begin
      int k = (i - 24) % 8;
      if (acc_q[i].d !== FB[k] || acc_q[i].x !== 10'(k % 4) || acc_q[i].y !== 9'(k / 4))
        e++;
    end
    total++; if (e != 0 || n < 48) begin bad++;
      $display("FAIL bp_sequence: got %0d wrong of %0d want 0", e, n); end
  endtask

  task automatic test_reset_mid();
    int f0;
    wait_pix(((acc_q.size() / 8) + 1) * 8 + 3);
    f0 = flip_cnt;
    @(posedge clk); #2 n_rst = 1'b1;
    #1;
    total++; if ({flip, pix_valid, busy, parity_err, pix_sof, pix_eol, pix_eof} !== 7'b0) begin
      bad++; $display("FAIL async_reset_ctl: got %b want 0",
                      {flip, pix_valid, busy, parity_err, pix_sof, pix_eol, pix_eof}); end
    total++; if ({read_addr, err_row, pix_x, pix_y, pix_data} !== '0) begin bad++;
      $display("FAIL async_reset_val: got %h want 0",
               {read_addr, err_row, pix_x, pix_y, pix_data}); end
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    repeat (10) tick();
    total++; if (busy !== 1'b0 || flip_cnt != f0 || pix_valid !== 1'b0) begin bad++;
      $display("FAIL idle_after_mid_reset: busy=%b flips=%0d want 0/%0d", busy, flip_cnt, f0); end
    pulse_frame();
    for (int i = 0; i < 20; i++) begin
      if (flip_cnt != f0) break;
      tick();
    end
    total++; if (flip_cnt != f0 + 1) begin bad++;
      $display("FAIL restart_flip: got %0d want %0d", flip_cnt, f0 + 1); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_rescan();
    test_pending_parity();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wireframe_scanout.md
# wireframe_scanout

Read-side engine for the double-buffered wireframe SRAM. Walks the display buffer row by row, strips and checks the per-row parity bit, and streams pixels with coordinates over a valid/ready interface to the display stage. Owns the `flip` strobe: it swaps buffers only on a frame boundary, once the rasterizer has signalled a finished frame.

## Interface

Parameters:
- `WIDTH`, default 640: pixels per row.
- `HEIGHT`, default 480: rows per frame.
- `WIREFRAME_ADDR_SIZE`, default 19: SRAM address width. Must hold `(WIDTH+1)*HEIGHT-1`.

Ports:
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `n_rst`, in, 1: asynchronous, active-high reset; asserted when 1.
- `frame_ready`, in, 1: one-cycle pulse from the rasterizer meaning the write buffer holds a complete frame.
- `flip`, out, 1: one-cycle strobe to the SRAM that swaps the read and write buffers.
- `read_addr`, out, `WIREFRAME_ADDR_SIZE`: SRAM read address.
- `sram_data`, in, 1: SRAM `data_out`, valid 1 cycle after `read_addr`.
- `pix_valid`, out, 1: output pixel valid.
- `pix_ready`, in, 1: downstream accepts the pixel.
- `pix_data`, out, 1: pixel value.
- `pix_x`, out, 10: column of the pixel.
- `pix_y`, out, 9: row of the pixel.
- `pix_sof`, out, 1: set on pixel (0,0).
- `pix_eol`, out, 1: set on `x = WIDTH-1`.
- `pix_eof`, out, 1: set on the last pixel of the frame.
- `parity_err`, out, 1: one-cycle pulse when a row's parity check fails.
- `err_row`, out, 9: row of the most recent parity error; holds until the next error.
- `busy`, out, 1: high in every state except IDLE.

## Operation

Memory layout:
- Row `r` occupies addresses `r*(WIDTH+1)` to `r*(WIDTH+1)+WIDTH`.
- The last address of each row holds the parity bit.
- Parity is even over the row: the XOR of the `WIDTH` pixels and the parity bit must be 0.

State machine:
- **IDLE**: entered on reset.
  - Moves to FLIP when `frame_pending` is set.
- **FLIP**: lasts exactly 1 cycle.
  - Drives `flip=1`, clears `frame_pending`, resets the address and the x/y counters to 0.
  - Always moves to READ.
- **READ**: issues addresses linearly, one per cycle, while the credit rule below allows.
  - Issue order per row is x = 0..WIDTH, where x = WIDTH is the parity read.
  - After issuing the parity address of row `HEIGHT-1`, moves to DRAIN.
- **DRAIN**: waits for the last return to land and the output buffer to empty.
  - Then moves to FLIP if `frame_pending` is set.
  - Otherwise it rescans the same buffer: address and counters go to 0 and the state goes to READ. The display never starves.

`frame_pending` flag:
- Set by `frame_ready` in any state.
- A `frame_ready` pulse in the same cycle as FLIP leaves the flag set, so the new frame is not lost.

Output buffer and credit rule:
- A 2-entry FIFO holds {data, x, y, sof, eol, eof}.
- A read may issue only when (FIFO occupancy + reads in flight) < 2. Backpressure therefore never drops SRAM data.
- Parity reads do not consume FIFO space and are never emitted as pixels.
- A running XOR accumulates each returned pixel of the row.
- When the parity bit returns, if accumulator XOR parity = 1: pulse `parity_err` on the next cycle and load `err_row` with that row. The accumulator then clears.

Handshake:
- A pixel transfers on a cycle where `pix_valid && pix_ready`.
- While `pix_valid` is high, `pix_data`, `pix_x`, `pix_y` and the sideband bits are held stable.

## Timing

- Reset values: `flip=0`, `read_addr=0`, `pix_valid=0`, `pix_data=0`, `pix_x=0`, `pix_y=0`, `pix_sof=0`, `pix_eol=0`, `pix_eof=0`, `parity_err=0`, `err_row=0`, `busy=0`, `frame_pending=0`, FIFO empty, state IDLE.
- `frame_ready` at edge N: FLIP at N+1 and first read issued at N+2. This respects the SRAM rule that reads after the flip edge hit the new buffer.
- Latency from address issue to `pix_valid`: 2 cycles, via the SRAM register and the FIFO write.
- With `pix_ready` held at 1, throughput is 1 pixel per cycle except one bubble per row for the parity read. A frame takes `(WIDTH+1)*HEIGHT` read cycles.
- Reset mid-frame clears the FIFO, counters and `frame_pending` immediately. No `flip` is generated during or after reset until a new `frame_ready`.

## Test plan

All scenarios use `WIDTH=4`, `HEIGHT=2` and a behavioural SRAM model.

1. **Basic scan.** Reset, then pulse `frame_ready` with rows 1010/p0 and 0111/p1 and `pix_ready=1`.
   - Required: exactly one `flip` pulse.
   - Addresses 0..9 issued in order.
   - 8 pixels delivered with correct x/y; `pix_sof` on (0,0), `pix_eol` on x=3, `pix_eof` on (3,1).
   - No `parity_err`.
2. **Parity error.** Corrupt row 1 parity to 0.
   - Required: `parity_err` pulses once, 1 cycle after address 9 returns; `err_row=1`; pixels still delivered.
3. **Backpressure.** Toggle `pix_ready` randomly, then hold it at 0 for 10 cycles.
   - Required: at most 2 reads outstanding; no pixel lost or duplicated; outputs stable while stalled.
4. **Rescan.** No second `frame_ready`.
   - Required: after `pix_eof` the same 8 pixels repeat, with no `flip`.
5. **Pending frame.** `frame_ready` mid-frame.
   - Required: `flip` pulses only after the `pix_eof` transfer and the drain complete; the next frame reads the new buffer.
6. **Reset mid-frame.** Assert `n_rst` after 3 pixels.
   - Required: all outputs return to reset values asynchronously; IDLE until the next `frame_ready`.
